voter4_ballot: RTL
==================

Name: voter4_ballot

Overview:
Sequential ballot collector that is the input-side counterpart of the combinational 4-input majority voter. Runs a timed voting session. Synchronizes and debounces four raw voter buttons (a, b, c, d) and accepts one "yes" press per voter. At session close it tallies the yes votes and drives the result LED. Sits between the board push-buttons and the result LED in the safe-communication demo design.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable samples required before a button level is accepted (>=1)
VOTE_WINDOW, 1000, clock cycles a session stays open before automatic close (>=1)
PASS_THRESHOLD, 3, minimum yes votes for led=1 (1..4)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
start  input  1  one-cycle pulse: open a new session
close  input  1  one-cycle pulse: close the open session early
a  input  1  voter 0 raw button, asynchronous, active-high
b  input  1  voter 1 raw button
c  input  1  voter 2 raw button
d  input  1  voter 3 raw button
ballot_open  output  1  high while the session accepts votes
voted  output  4  per-voter "has voted" flags, bit0=a … bit3=d
yes_count  output  3  running tally 0..4
result_valid  output  1  one-cycle pulse when the tally is final
led  output  1  1 = motion passed (yes_count >= PASS_THRESHOLD), held until next start

Behaviour:
- Reset (rst_n=0 at a clk edge) returns FSM to IDLE. Reset values: ballot_open=0, voted=0, yes_count=0, result_valid=0, led=0, synchronizers and debounce counters cleared. Applies in any state, including mid-session; any partial tally is discarded.
- Input path per button: 2-FF synchronizer, then debouncer. The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count. A vote event is a 0->1 edge of the debounced level.
- Press-to-count latency: 2 (sync) + DEBOUNCE_CYCLES + 1 (edge/register) cycles.
- FSM states: IDLE, OPEN, TALLY, SHOW.
- IDLE: ballot_open=0. start -> OPEN; voted, yes_count and led cleared and window counter loaded to VOTE_WINDOW-1 on the same edge.
- OPEN: ballot_open=1.
  - A vote event for voter i with voted[i]=0 sets voted[i] and increments yes_count.
  - Events with voted[i]=1 are ignored; no double voting.
  - Simultaneous events from several voters in one cycle are all counted (add popcount).
  - Window counter decrements each cycle. close=1 or counter==0 -> TALLY.
  - A vote event in the same cycle as close or expiry is counted.
  - start while OPEN is ignored.
- TALLY: one cycle. ballot_open=0. led <= (yes_count >= PASS_THRESHOLD). -> SHOW with result_valid=1 for exactly that transition cycle.
- SHOW: led and yes_count held. start -> OPEN with the same clears as from IDLE. close ignored. Presses are ignored in IDLE, TALLY and SHOW.
- yes_count never exceeds 4. Width is 3 bits, so there is no wrap.
- Buttons held across session open do not vote until released and re-pressed, because an edge is required.

Decomposition:
- Shared package voter_pkg: state encoding (IDLE=2'd0, OPEN=2'd1, TALLY=2'd2, SHOW=2'd3), N_VOTERS=4 constant.
- One sub-module, btn_debounce (sync + debounce + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated four times.
- FSM and tally stay in voter4_ballot.

Test Plan:
1. Reset mid-session: start, press a and b, assert rst_n=0 for 1 cycle -> ballot_open=0, voted=0, yes_count=0, led=0; later presses are not counted.
2. Pass: start, clean presses on a, b, c, then close -> yes_count=3, voted=4'b0111, result_valid pulses once, led=1 held until next start.
3. Fail plus double vote: start, press a three times and d once, let the window expire (VOTE_WINDOW=50) -> yes_count=2, voted=4'b1001, led=0, result_valid one cycle after expiry.
4. Debounce: start, toggle b high for DEBOUNCE_CYCLES-1 cycles, then low, repeated 5 times; then hold c for 10 cycles -> only c counted, yes_count=1.
5. Simultaneous and boundary: a, b, c, d asserted in the same cycle, with their debounced edges landing in the same cycle as close -> yes_count=4, voted=4'b1111, led=1.
6. Control races: start while OPEN leaves the counter and tally unchanged; close in IDLE or SHOW has no effect; start in SHOW clears led and yes_count in the next cycle, with ballot_open=1.

Source files
------------

// File: rtl/voter4_ballot_pkg.sv
// Shared definitions for the ballot collector: FSM encoding, voter count and a tally helper.
package voter_pkg;

  localparam int unsigned N_VOTERS = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOpen  = 2'd1,
    StTally = 2'd2,
    StShow  = 2'd3
  } state_e;

  function automatic logic [2:0] popcount(input logic [N_VOTERS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < N_VOTERS; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/voter4_ballot_if.sv
// Session control, raw buttons and result signals of the ballot collector.
interface voter4_ballot_if;
  import voter_pkg::*;

  logic                start;
  logic                close;
  logic                a;
  logic                b;
  logic                c;
  logic                d;
  logic                ballot_open;
  logic [N_VOTERS-1:0] voted;
  logic [2:0]          yes_count;
  logic                result_valid;
  logic                led;

  modport master (
    output start, close, a, b, c, d,
    input  ballot_open, voted, yes_count, result_valid, led
  );

  modport slave (
    input  start, close, a, b, c, d,
    output ballot_open, voted, yes_count, result_valid, led
  );

endinterface

// File: rtl/voter4_ballot_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability debouncer and registered rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the accepted level restarts the stability count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/voter4_ballot.sv
// Timed ballot session: conditions four voter buttons, accepts one yes per voter, drives the LED.
module voter4_ballot
  import voter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned VOTE_WINDOW     = 1000,
  parameter int unsigned PASS_THRESHOLD  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  voter4_ballot_if.slave  bus
);

  localparam int unsigned WW = (VOTE_WINDOW > 1) ? $clog2(VOTE_WINDOW) : 1;

  logic [N_VOTERS-1:0] raw, rise, new_votes;
  state_e              state_q, state_d;
  logic [N_VOTERS-1:0] voted_q, voted_d;
  logic [2:0]          yes_count_q, yes_count_d;
  logic                led_q, led_d;
  logic [WW-1:0]       win_q, win_d;

  assign raw = {bus.d, bus.c, bus.b, bus.a};

  for (genvar i = 0; i < N_VOTERS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[i]),
      .rise (rise[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      voted_q     <= '0;
      yes_count_q <= '0;
      led_q       <= 1'b0;
      win_q       <= '0;
    end else begin
      state_q     <= state_d;
      voted_q     <= voted_d;
      yes_count_q <= yes_count_d;
      led_q       <= led_d;
      win_q       <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StOpen;
      StOpen:  if (bus.close || (win_q == '0)) state_d = StTally;
      StTally: state_d = StShow;
      StShow:  if (bus.start) state_d = StOpen;
      default: state_d = StIdle;
    endcase
  end

  // Votes arriving in the closing cycle still count because OPEN is the current state.
  always_comb begin
    voted_d     = voted_q;
    yes_count_d = yes_count_q;
    led_d       = led_q;
    win_d       = win_q;
    new_votes   = '0;
    unique case (state_q)
      StIdle, StShow: begin
        if (bus.start) begin
          voted_d     = '0;
          yes_count_d = '0;
          led_d       = 1'b0;
          win_d       = WW'(VOTE_WINDOW - 1);
        end
      end
      StOpen: begin
        new_votes   = rise & ~voted_q;
        voted_d     = voted_q | new_votes;
        yes_count_d = yes_count_q + popcount(new_votes);
        if (win_q != '0) win_d = win_q - WW'(1);
      end
      StTally: led_d = ({29'd0, yes_count_q} >= PASS_THRESHOLD);
      default: ;
    endcase
  end

  always_comb begin
    bus.ballot_open  = (state_q == StOpen);
    bus.result_valid = (state_q == StTally);
    bus.voted        = voted_q;
    bus.yes_count    = yes_count_q;
    bus.led          = led_q;
  end

endmodule
